// File: rtl/uart_fifo_mmio_if.sv
// Pipeline data-bus port of the memory-mapped UART.
// The upstream decode drives sel; the core drives the access strobe and the write data.
interface uart_fifo_mmio_if;
  logic        sel;
  logic        valid;
  logic        write;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [2:0]  addr;
  logic [31:0] rdata;

  modport master (output sel, valid, write, wmask, wdata, addr, input rdata);
  modport slave  (input sel, valid, write, wmask, wdata, addr, output rdata);
endinterface

// File: rtl/uart_fifo_mmio.sv
// Memory-mapped UART: RX/TX FIFOs, run-time baud divisor, sticky error flags and an RX interrupt.
// Frames are 8N1 on receive and 8N1/8N2 on transmit; each bit lasts exactly the divisor latched at frame start.
module uart_fifo_mmio #(
  parameter int DIV_RESET = 104,
  parameter int DIV_WIDTH = 16,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            rstn,
  uart_fifo_mmio_if.slave bus,
  input  logic            uart_rx,
  output logic            uart_tx,
  output logic            irq_rx
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(4);
  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DIV_RESET);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  logic acc, wr, rd;
  logic tx_push_req, div_wr, stat_wr, rx_pop_req;
  assign acc         = bus.sel & bus.valid;
  assign wr          = acc & bus.write;
  assign rd          = acc & ~bus.write;
  assign tx_push_req = wr && bus.addr == 3'd0 && bus.wmask[0];
  assign div_wr      = wr && bus.addr == 3'd2 && bus.wmask[1:0] == 2'b11;
  assign stat_wr     = wr && bus.addr == 3'd4 && bus.wmask[0];
  assign rx_pop_req  = rd && bus.addr == 3'd1;

  logic unused_bits;
  assign unused_bits = ^{bus.wdata[31:DIV_WIDTH], bus.wmask[3:2]};

  // Shared state
  logic [7:0]           tx_mem [TX_DEPTH];
  logic [7:0]           rx_mem [RX_DEPTH];
  logic [TX_AW:0]       tx_wptr_q, tx_rptr_q;
  logic [RX_AW:0]       rx_wptr_q, rx_rptr_q;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [2:0]           flags_q, flags_d;   // {txovf, ferr, rxovr}
  logic [31:0]          rdata_q, rdata_d;

  uart_state_e          tx_state_q, rx_state_q;
  logic [DIV_WIDTH-1:0] tx_cnt_q, tx_div_q, rx_cnt_q, rx_div_q;
  logic [7:0]           tx_shift_q, rx_shift_q;
  logic [2:0]           tx_bit_q, rx_bit_q;
  logic                 tx_stop_q, uart_tx_q;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;

  // Extra pointer MSB distinguishes full (MSBs differ, rest equal) from empty.
  logic tx_empty, tx_full, tx_push, tx_pop, tx_period_end, tx_stop_last, tx_idle;
  assign tx_empty      = tx_wptr_q == tx_rptr_q;
  assign tx_full       = (tx_wptr_q[TX_AW] != tx_rptr_q[TX_AW]) &&
                         (tx_wptr_q[TX_AW-1:0] == tx_rptr_q[TX_AW-1:0]);
  assign tx_push       = tx_push_req & ~tx_full;
  assign tx_period_end = tx_cnt_q == tx_div_q - DIV_ONE;
  assign tx_stop_last  = tx_stop_q == 1'(STOP_BITS - 1);
  assign tx_pop        = ~tx_empty & ((tx_state_q == S_IDLE) |
                         (tx_state_q == S_STOP & tx_period_end & tx_stop_last));
  assign tx_idle       = tx_empty & (tx_state_q == S_IDLE);

  logic rx_empty, rx_full, rx_pop, rx_push_req, rx_push, rx_ovr_set, rx_ferr_set;
  logic rx_period_end, rx_half_end;
  assign rx_empty      = rx_wptr_q == rx_rptr_q;
  assign rx_full       = (rx_wptr_q[RX_AW] != rx_rptr_q[RX_AW]) &&
                         (rx_wptr_q[RX_AW-1:0] == rx_rptr_q[RX_AW-1:0]);
  assign rx_pop        = rx_pop_req & ~rx_empty;
  assign rx_period_end = rx_cnt_q == rx_div_q - DIV_ONE;
  assign rx_half_end   = rx_cnt_q == {1'b0, rx_div_q[DIV_WIDTH-1:1]} - DIV_ONE;
  assign rx_push_req   = (rx_state_q == S_STOP) & rx_period_end & rx_s2_q;
  assign rx_ferr_set   = (rx_state_q == S_STOP) & rx_period_end & ~rx_s2_q;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign rx_push       = rx_push_req & (~rx_full | rx_pop);
  assign rx_ovr_set    = rx_push_req & rx_full & ~rx_pop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    div_d   = (bus.wdata[DIV_WIDTH-1:0] < DIV_MIN) ? DIV_MIN : bus.wdata[DIV_WIDTH-1:0];
    flags_d = stat_wr ? (flags_q & ~bus.wdata[5:3]) : flags_q;
    if (rx_ovr_set)               flags_d[0] = 1'b1;
    if (rx_ferr_set)              flags_d[1] = 1'b1;
    if (tx_push_req && tx_full)   flags_d[2] = 1'b1;
    rdata_d = '0;
    case (bus.addr)
      3'd1:    rdata_d = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_mem[rx_rptr_q[RX_AW-1:0]]};
      3'd2:    rdata_d = 32'(div_q);
      3'd4:    rdata_d = {26'h0, flags_q, tx_idle, ~rx_empty, ~tx_full};
      default: rdata_d = '0;
    endcase
  end

  // NOTE: FIFO storage is not reset; the pointers alone define occupancy, which keeps the arrays RAM-mappable.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q[TX_AW-1:0]] <= bus.wdata[7:0];
    if (rx_push) rx_mem[rx_wptr_q[RX_AW-1:0]] <= rx_shift_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      div_q     <= DIV_RST;
      flags_q   <= '0;
      rdata_q   <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + (TX_AW+1)'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + (TX_AW+1)'(1);
      if (rx_push) rx_wptr_q <= rx_wptr_q + (RX_AW+1)'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + (RX_AW+1)'(1);
      if (div_wr)  div_q     <= div_d;
      flags_q <= flags_d;
      if (rd)      rdata_q   <= rdata_d;
    end
  end

  // TX FSM: a pending byte is popped on entering START, straight from STOP when back-to-back.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_RST;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      uart_tx_q  <= 1'b1;
    end else if (tx_pop) begin
      tx_state_q <= S_START;
      tx_cnt_q   <= '0;
      tx_div_q   <= div_q;
      tx_shift_q <= tx_mem[tx_rptr_q[TX_AW-1:0]];
      uart_tx_q  <= 1'b0;
    end else if (tx_state_q != S_IDLE) begin
      if (!tx_period_end) begin
        tx_cnt_q <= tx_cnt_q + DIV_ONE;
      end else begin
        tx_cnt_q <= '0;
        case (tx_state_q)
          S_START: begin
            tx_state_q <= S_DATA;
            tx_bit_q   <= '0;
            uart_tx_q  <= tx_shift_q[0];
          end
          S_DATA: begin
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= S_STOP;
              tx_stop_q  <= 1'b0;
              uart_tx_q  <= 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              uart_tx_q  <= tx_shift_q[1];
            end
          end
          S_STOP: begin
            if (tx_stop_last) tx_state_q <= S_IDLE;
            else              tx_stop_q  <= tx_stop_q + 1'b1;
          end
          default: tx_state_q <= S_IDLE;
        endcase
      end
    end
  end

  // RX FSM: start validated at half a bit, then every sample lands mid-bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_RST;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      case (rx_state_q)
        S_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_state_q <= S_START;
            rx_cnt_q   <= '0;
            rx_div_q   <= div_q;
          end
        end
        S_START: begin
          if (rx_half_end) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + DIV_ONE;
          end
        end
        S_DATA: begin
          if (rx_period_end) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + DIV_ONE;
          end
        end
        S_STOP: begin
          if (rx_period_end) begin
            rx_cnt_q   <= '0;
            rx_state_q <= S_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + DIV_ONE;
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  assign uart_tx   = uart_tx_q;
  assign irq_rx    = ~rx_empty;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Self-checking bench for uart_fifo_mmio: scoreboards for TX line frames and RXDATA reads.
// Bus inputs and the serial line are driven at negedges; outputs are sampled at negedges.
module tb_uart_fifo_mmio;
  localparam int DIV           = 8;
  localparam int DEPTH         = 16;
  localparam int STOP_BITS     = 1;
  localparam int FRAME_SAMPLES = (9 + STOP_BITS) * DIV;

  logic clk     = 1'b0;
  logic rstn    = 1'b0;
  logic uart_rx = 1'b1;
  logic uart_tx, irq_rx;

  uart_fifo_mmio_if bus();

  uart_fifo_mmio #(
    .DIV_RESET(DIV), .DIV_WIDTH(16), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH), .STOP_BITS(STOP_BITS)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq_rx(irq_rx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  int         tx_start_q[$];
  logic       tx_mon_en = 1'b1;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All bus tasks start right after a negedge and return right after one.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.sel = 1'b1; bus.valid = 1'b1; bus.write = 1'b1;
    bus.addr = a; bus.wdata = d; bus.wmask = m;
    @(negedge clk);
    bus.sel = 1'b0; bus.valid = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.sel = 1'b1; bus.valid = 1'b1; bus.write = 1'b0;
    bus.addr = a; bus.wdata = '0; bus.wmask = '0;
    @(negedge clk);
    d = bus.rdata;
    bus.sel = 1'b0; bus.valid = 1'b0;
  endtask

  task automatic tx_write(input logic [7:0] b);
    tx_exp_q.push_back(b);
    bus_write(3'd0, {24'h0, b}, 4'b0001);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    if (stop && rx_exp_q.size() < DEPTH) rx_exp_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic rx_read_check();
    logic [31:0] d;
    bus_read(3'd1, d);
    if (rx_exp_q.size() == 0) check("rxdata", d, 32'hFFFF_FFFF);
    else                      check("rxdata", d, {24'h0, rx_exp_q.pop_front()});
  endtask

  task automatic wait_tx_idle();
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      bus_read(3'd4, s);
      n++;
    end while (!s[2] && n < 5000);
    check("tx_idle_wait", 32'(s[2]), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Decodes every TX frame: each slot must hold its level for exactly DIV cycles.
  initial begin : tx_monitor
    logic [7:0]  got;
    logic [31:0] exp;
    logic        lvl;
    int          bad, slot;
    forever begin
      @(negedge clk);
      if (tx_mon_en && rstn && uart_tx === 1'b0) begin
        got = '0;
        bad = 0;
        tx_start_q.push_back(cyc);
        for (int s = 0; s < FRAME_SAMPLES; s++) begin
          if (s != 0) @(negedge clk);
          slot = s / DIV;
          if (slot == 0) begin
            lvl = 1'b0;
          end else if (slot <= 8) begin
            if (s % DIV == 0) got[slot-1] = uart_tx;
            lvl = got[slot-1];
          end else begin
            lvl = 1'b1;
          end
          if (uart_tx !== lvl) bad++;
        end
        check("tx_bit_timing", 32'(bad), 32'd0);
        exp = (tx_exp_q.size() != 0) ? {24'h0, tx_exp_q.pop_front()} : 32'hFFFF_FFFF;
        check("tx_byte", {24'h0, got}, exp);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] d;
    int zeros;
    bus.sel = 1'b0; bus.valid = 1'b0; bus.write = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.wmask = '0;

    // Reset
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("reset_uart_tx", 32'(uart_tx), 32'd1);
    check("reset_irq", 32'(irq_rx), 32'd0);
    check("reset_rdata", bus.rdata, 32'd0);
    bus_read(3'd4, d);
    check("reset_status", d, 32'h5);

    // TX back-to-back
    tx_start_q.delete();
    tx_write(8'h55);
    tx_write(8'hA3);
    wait_tx_idle();
    check("tx_frames", 32'(tx_start_q.size()), 32'd2);
    if (tx_start_q.size() >= 2)
      check("tx_no_gap", 32'(tx_start_q[1] - tx_start_q[0]), 32'(10 * DIV));
    bus_read(3'd4, d);
    check("status_after_tx", d, 32'h5);

    // RX single byte
    send_rx(8'hC4, 1'b1);
    check("irq_rx_set", 32'(irq_rx), 32'd1);
    rx_read_check();
    check("irq_rx_clear", 32'(irq_rx), 32'd0);
    rx_read_check();
    repeat (3) @(negedge clk);
    check("rdata_hold_empty", bus.rdata, 32'hFFFF_FFFF);

    // RX overrun
    for (int i = 0; i < DEPTH + 1; i++) send_rx(8'(8'h30 + i), 1'b1);
    bus_read(3'd4, d);
    check("status_rxovr", d, 32'hF);
    for (int i = 0; i < DEPTH + 1; i++) rx_read_check();
    bus_read(3'd4, d);
    check("status_rx_drained", d, 32'hD);

    // Framing error, then a short glitch
    send_rx(8'h5A, 1'b0);
    bus_read(3'd4, d);
    check("status_ferr", d, 32'h1D);
    check("irq_after_ferr", 32'(irq_rx), 32'd0);
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    check("irq_after_glitch", 32'(irq_rx), 32'd0);
    rx_read_check();

    // TX overflow while busy, then sticky clear
    tx_write(8'h80);
    repeat (2) @(negedge clk);
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i < DEPTH) tx_write(8'(8'h81 + i));
      else           bus_write(3'd0, 32'h0000_00EE, 4'b0001);
    end
    bus_read(3'd4, d);
    check("status_txovf", d, 32'h38);
    bus_write(3'd4, 32'h38, 4'b0001);
    bus_read(3'd4, d);
    check("status_cleared", d, 32'h0);
    wait_tx_idle();
    bus_read(3'd4, d);
    check("status_tx_drained", d, 32'h5);

    // Divisor register
    bus_write(3'd2, 32'd2, 4'b0011);
    bus_read(3'd2, d);
    check("div_min_clamp", d, 32'd4);
    bus_write(3'd2, 32'd100, 4'b0001);
    bus_read(3'd2, d);
    check("div_partial_mask", d, 32'd4);
    bus_write(3'd2, 32'(DIV), 4'b0011);
    bus_read(3'd2, d);
    check("div_restore", d, 32'(DIV));
    bus_write(3'd5, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    check("rdata_hold", bus.rdata, 32'(DIV));
    bus_read(3'd5, d);
    check("unmapped_read", d, 32'h0);

    // Divisor change mid-frame: the current frame keeps DIV cycles/bit
    tx_write(8'h3C);
    repeat (30) @(negedge clk);
    bus_write(3'd2, 32'd16, 4'b0011);
    wait_tx_idle();
    bus_read(3'd2, d);
    check("div_new_value", d, 32'd16);
    bus_write(3'd2, 32'(DIV), 4'b0011);

    // Reset during TX DATA
    tx_mon_en = 1'b0;
    bus_write(3'd0, 32'h00, 4'b0001);
    bus_write(3'd0, 32'h11, 4'b0001);
    bus_write(3'd0, 32'h22, 4'b0001);
    repeat (20) @(negedge clk);
    check("tx_mid_frame", 32'(uart_tx), 32'd0);
    rstn = 1'b0;
    @(negedge clk);
    check("tx_reset_next", 32'(uart_tx), 32'd1);
    rstn = 1'b1;
    bus_read(3'd4, d);
    check("status_after_reset", d, 32'h5);
    bus_read(3'd2, d);
    check("div_after_reset", d, 32'(DIV));
    check("irq_after_reset", 32'(irq_rx), 32'd0);
    rx_read_check();
    zeros = 0;
    for (int i = 0; i < 12 * DIV; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) zeros++;
    end
    check("tx_no_residual", 32'(zeros), 32'd0);

    check("tx_pending", 32'(tx_exp_q.size()), 32'd0);
    check("rx_pending", 32'(rx_exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
